oam_dma_controller: RTL and testbench

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

---
 rtl/nes_pkg.sv | 25 ++
 rtl/oam_dma_controller.sv | 183 ++++++++++++++++++
 tb/tb_oam_dma_controller.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
//   Shared definitions for the NES CPU-side DMA logic: the OAM DMA state
//   enumeration, the two register addresses the DMA engine cares about, and
//   the encoding of the CPU GET/PUT cycle parity.
// -----------------------------------------------------------------------------
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HALT     = 3'd1,
        ST_ALIGN    = 3'd2,
        ST_READ     = 3'd3,
        ST_WRITE    = 3'd4,
        ST_DMC_READ = 3'd5
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    // Parity 0 is a GET (read) cycle, parity 1 is a PUT (write) cycle.
    localparam logic PARITY_GET = 1'b0;
    localparam logic PARITY_PUT = 1'b1;

endpackage : nes_pkg

// File: rtl/oam_dma_controller.sv
// -----------------------------------------------------------------------------
// oam_dma_controller
//   NES sprite (OAM) DMA engine with APU DMC sample-fetch arbitration.
//   A CPU write to $4014 halts the CPU and copies page $XX00-$XXFF into $2004
//   as 256 READ/WRITE pairs aligned to GET/PUT cycles. DMC fetch requests are
//   latched and steal the next GET slot, either from IDLE or in the middle of
//   an OAM transfer.
//
// Ports
//   cpu_clk_in          CPU-rate clock, rising edge active
//   rst_n_in            asynchronous active-low reset
//   cpu_write_in        CPU write strobe
//   cpu_address_in      CPU address bus
//   cpu_data_in         CPU write data (page number on a $4014 write)
//   ram_data_in         bus read data for dma_address_out
//   dmc_req_in          DMC fetch request, one-cycle pulse
//   dmc_address_in      DMC fetch address, valid with dmc_req_in
//   dma_address_en_out  DMA owns the address bus
//   dma_address_out     DMA bus address (0 when the bus is not owned)
//   dma_write_out       DMA write strobe to $2004
//   dma_data_out        DMA write data (last byte read from RAM)
//   cpu_disable_out     CPU RDY low / CPU halted
//   dmc_ack_out         one-cycle pulse, dmc_data_out valid alongside
//   dmc_data_out        fetched DMC byte
// -----------------------------------------------------------------------------
module oam_dma_controller (
    input  logic        cpu_clk_in,
    input  logic        rst_n_in,
    input  logic        cpu_write_in,
    input  logic [15:0] cpu_address_in,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  ram_data_in,
    input  logic        dmc_req_in,
    input  logic [15:0] dmc_address_in,
    output logic        dma_address_en_out,
    output logic [15:0] dma_address_out,
    output logic        dma_write_out,
    output logic [7:0]  dma_data_out,
    output logic        cpu_disable_out,
    output logic        dmc_ack_out,
    output logic [7:0]  dmc_data_out
);

    import nes_pkg::*;

    dma_state_t  r_state;
    logic        r_parity;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic [7:0]  r_data;
    logic        r_dmc_pending;
    logic [15:0] r_dmc_addr;
    logic        r_oam_active;

    logic        w_oamdma_write;
    logic        w_next_is_get;
    dma_state_t  w_get_slot_state;

    assign w_oamdma_write = cpu_write_in && (cpu_address_in == OAMDMA_ADDR);

    // The current cycle being a PUT means the following cycle is a GET.
    assign w_next_is_get = (r_parity == PARITY_PUT);

    // What the next GET slot is used for: a pending DMC fetch wins over the
    // OAM read; with nothing left to do the engine releases the CPU.
    // NOTE: every signal assigned in an always_comb block gets a default value
    // first, so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_get_slot_state = ST_IDLE;
        if (r_dmc_pending) begin
            w_get_slot_state = ST_DMC_READ;
        end else if (r_oam_active) begin
            w_get_slot_state = ST_READ;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge cpu_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_IDLE;
            r_parity      <= PARITY_GET;
            r_page        <= 8'h00;
            r_index       <= 8'h00;
            r_data        <= 8'h00;
            r_dmc_pending <= 1'b0;
            r_dmc_addr    <= 16'h0000;
            r_oam_active  <= 1'b0;
        end else begin
            r_parity <= ~r_parity;

            // A DMC request is remembered in every state until its slot comes.
            if (dmc_req_in) begin
                r_dmc_pending <= 1'b1;
                r_dmc_addr    <= dmc_address_in;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_oamdma_write) begin
                        r_page       <= cpu_data_in;
                        r_index      <= 8'h00;
                        r_oam_active <= 1'b1;
                        r_state      <= ST_HALT;
                    end else if (dmc_req_in || r_dmc_pending) begin
                        r_state <= ST_HALT;
                    end
                end

                ST_HALT: begin
                    r_state <= w_next_is_get ? w_get_slot_state : ST_ALIGN;
                end

                // ALIGN always sits on a PUT, so the next cycle is a GET.
                ST_ALIGN: begin
                    r_state <= w_get_slot_state;
                end

                ST_READ: begin
                    r_data  <= ram_data_in;
                    r_state <= ST_WRITE;
                end

                ST_WRITE: begin
                    r_index <= r_index + 8'd1;
                    if (r_index == 8'hFF) begin
                        r_oam_active <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_state <= w_get_slot_state;
                    end
                end

                ST_DMC_READ: begin
                    // Serviced now; a request arriving in this very cycle
                    // stays pending (this assignment overrides the one above).
                    r_dmc_pending <= dmc_req_in;
                    // Inside an OAM transfer the next cycle is a PUT: burn it
                    // in ALIGN and resume READ at the same index.
                    r_state       <= r_oam_active ? ST_ALIGN : ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus outputs are a pure decode of registered state, so reset clears them
    // immediately. The DMC byte is the live bus data during its own slot.
    always_comb begin
        dma_address_en_out = 1'b0;
        dma_address_out    = 16'h0000;
        dma_write_out      = 1'b0;
        dmc_ack_out        = 1'b0;
        dmc_data_out       = 8'h00;
        case (r_state)
            ST_READ: begin
                dma_address_en_out = 1'b1;
                dma_address_out    = {r_page, r_index};
            end
            ST_WRITE: begin
                dma_address_en_out = 1'b1;
                dma_write_out      = 1'b1;
                dma_address_out    = OAMDATA_ADDR;
            end
            ST_DMC_READ: begin
                dma_address_en_out = 1'b1;
                dma_address_out    = r_dmc_addr;
                dmc_ack_out        = 1'b1;
                dmc_data_out       = ram_data_in;
            end
            default: begin
                dma_address_en_out = 1'b0;
            end
        endcase
    end

    assign cpu_disable_out = (r_state != ST_IDLE);
    assign dma_data_out    = r_data;

endmodule : oam_dma_controller

// File: tb/tb_oam_dma_controller.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_controller
//   Scoreboard bench. Stimulus tasks push the expected OAM byte stream, DMC
//   fetch results and CPU-halt window lengths into queues when a request is
//   issued; a negedge monitor pops and compares whenever the DUT presents a
//   write, a DMC ack, a read address or the end of a halt window.
// -----------------------------------------------------------------------------
module tb_oam_dma_controller;

    localparam logic [15:0] REG_OAMDMA  = 16'h4014;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;

    typedef struct packed {
        logic [15:0] src;
        logic [7:0]  data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [7:0]  ram_data;
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        dma_wr;
    logic [7:0]  dma_data;
    logic        cpu_disable;
    logic        dmc_ack;
    logic [7:0]  dmc_data;

    logic [7:0]  mem [0:65535];

    exp_t oam_q[$];
    exp_t dmc_q[$];
    int   len_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int run_len  = 0;
    int cyc;

    oam_dma_controller dut (
        .cpu_clk_in         (clk),
        .rst_n_in           (rst_n),
        .cpu_write_in       (cpu_write),
        .cpu_address_in     (cpu_addr),
        .cpu_data_in        (cpu_data),
        .ram_data_in        (ram_data),
        .dmc_req_in         (dmc_req),
        .dmc_address_in     (dmc_addr),
        .dma_address_en_out (dma_en),
        .dma_address_out    (dma_addr),
        .dma_write_out      (dma_wr),
        .dma_data_out       (dma_data),
        .cpu_disable_out    (cpu_disable),
        .dmc_ack_out        (dmc_ack),
        .dmc_data_out       (dmc_data)
    );

    // The bench acts as system memory for whatever address the DMA drives.
    assign ram_data = mem[dma_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; its LSB is the GET(0)/PUT(1) parity.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: observed %0d where nothing was expected (t=%0t)", name, act, $time);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (cpu_disable) begin
                run_len++;
            end else if (run_len > 0) begin
                if (len_q.size() == 0) fail_now("unexpected_halt_window", run_len);
                else                   check("halt_cycles", run_len, len_q.pop_front());
                run_len = 0;
            end

            if (!dma_en) begin
                check("idle_write", {31'd0, dma_wr}, 32'd0);
                check("idle_addr", {16'd0, dma_addr}, 32'd0);
                check("idle_ack", {31'd0, dmc_ack}, 32'd0);
            end else if (dma_wr) begin
                exp_t e;
                n_writes++;
                check("write_addr", {16'd0, dma_addr}, {16'd0, REG_OAMDATA});
                if (oam_q.size() == 0) begin
                    fail_now("unexpected_write", n_writes);
                end else begin
                    e = oam_q.pop_front();
                    check("oam_data", {24'd0, dma_data}, {24'd0, e.data});
                end
            end else if (dmc_ack) begin
                exp_t e;
                check("dmc_cpu_halted", {31'd0, cpu_disable}, 32'd1);
                if (dmc_q.size() == 0) begin
                    fail_now("unexpected_dmc_ack", {16'd0, dma_addr});
                end else begin
                    e = dmc_q.pop_front();
                    check("dmc_addr", {16'd0, dma_addr}, {16'd0, e.src});
                    check("dmc_data", {24'd0, dmc_data}, {24'd0, e.data});
                end
            end else begin
                // Bus owned without write or ack: an OAM read of the next byte.
                if (oam_q.size() == 0) fail_now("unexpected_read", {16'd0, dma_addr});
                else check("read_addr", {16'd0, dma_addr}, {16'd0, oam_q[0].src});
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    // One-cycle CPU write and/or DMC pulse. want_halt (0 GET, 1 PUT, -1 any)
    // delays the pulse until the following cycle has the requested parity.
    // extra_dmc is the number of DMC fetches the caller will land inside this
    // transfer; each costs one DMC slot plus one realignment cycle.
    task automatic issue(input bit wr, input logic [15:0] wa, input logic [7:0] wd,
                         input bit dreq, input logic [15:0] da,
                         input int extra_dmc, input int want_halt);
        bit busy;
        bit accepted;
        int halt_get;
        exp_t e;
        logic [15:0] a;
        @(posedge clk); #1;
        while (want_halt >= 0 && ((cyc + 1) % 2) != want_halt) begin
            @(posedge clk); #1;
        end
        halt_get = (((cyc + 1) % 2) == 0) ? 1 : 0;
        busy     = (oam_q.size() != 0) || (len_q.size() != 0);
        accepted = 1'b0;
        if (wr && wa == REG_OAMDMA && !busy) begin
            for (int i = 0; i < 256; i++) begin
                a = {wd, 8'(i)};
                e.src  = a;
                e.data = mem[a];
                oam_q.push_back(e);
            end
            len_q.push_back(513 + halt_get + 2 * extra_dmc);
            accepted = 1'b1;
        end
        if (dreq) begin
            e.src  = da;
            e.data = mem[da];
            dmc_q.push_back(e);
            if (!busy && !accepted) len_q.push_back(2 + halt_get);
        end
        cpu_write = wr;
        cpu_addr  = wa;
        cpu_data  = wd;
        dmc_req   = dreq;
        dmc_addr  = da;
        @(posedge clk); #1;
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_data  = 8'h00;
        dmc_req   = 1'b0;
        dmc_addr  = 16'h0000;
    endtask

    task automatic wait_writes(input int target);
        int t = 0;
        while (n_writes < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (n_writes < target) fail_now("wait_writes_timeout", n_writes);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((oam_q.size() != 0 || dmc_q.size() != 0 || len_q.size() != 0 || cpu_disable)
               && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) fail_now("wait_idle_timeout", oam_q.size());
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  page;
        logic [15:0] da;
        logic [15:0] wa;
        int base;
        int mode;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n     = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_data  = 8'h00;
        dmc_req   = 1'b0;
        dmc_addr  = 16'h0000;

        repeat (3) @(posedge clk);
        #2;
        check("rst_disable", {31'd0, cpu_disable}, 32'd0);
        check("rst_en", {31'd0, dma_en}, 32'd0);
        check("rst_addr", {16'd0, dma_addr}, 32'd0);
        check("rst_data", {24'd0, dma_data}, 32'd0);
        check("rst_ack", {31'd0, dmc_ack}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Page $02, HALT on PUT then on GET.
        issue(1'b1, REG_OAMDMA, 8'h02, 1'b0, 16'h0000, 0, 1);
        wait_idle();
        issue(1'b1, REG_OAMDMA, 8'h02, 1'b0, 16'h0000, 0, 0);
        wait_idle();

        // DMC at $C123 landing on the index $40 read slot (HALT on GET).
        base = n_writes;
        issue(1'b1, REG_OAMDMA, 8'h37, 1'b0, 16'h0000, 1, 0);
        wait_writes(base + 8'h3F);
        issue(1'b0, 16'h0000, 8'h00, 1'b1, 16'hC123, 0, -1);
        wait_idle();

        // DMC from IDLE, both alignments.
        issue(1'b0, 16'h0000, 8'h00, 1'b1, 16'h8A55, 0, 1);
        wait_idle();
        issue(1'b0, 16'h0000, 8'h00, 1'b1, 16'hFFF0, 0, 0);
        wait_idle();

        // Second $4014 write at index $80 is ignored.
        base = n_writes;
        issue(1'b1, REG_OAMDMA, 8'h05, 1'b0, 16'h0000, 0, -1);
        wait_writes(base + 8'h80);
        issue(1'b1, REG_OAMDMA, 8'h06, 1'b0, 16'h0000, 0, -1);
        wait_idle();

        // DMC request in the same cycle as the $4014 write.
        issue(1'b1, REG_OAMDMA, 8'h11, 1'b1, 16'h4321, 1, 1);
        wait_idle();

        // Randomized transfers, DMC placements and unrelated CPU writes.
        for (int r = 0; r < 10; r++) begin
            page = 8'($urandom);
            da   = 16'($urandom);
            mode = $urandom_range(0, 3);
            base = n_writes;
            case (mode)
                0: issue(1'b1, REG_OAMDMA, page, 1'b0, 16'h0000, 0, $urandom_range(0, 1));
                1: begin
                    issue(1'b1, REG_OAMDMA, page, 1'b0, 16'h0000, 1, $urandom_range(0, 1));
                    wait_writes(base + $urandom_range(1, 200));
                    issue(1'b0, 16'h0000, 8'h00, 1'b1, da, 0, -1);
                end
                2: issue(1'b1, REG_OAMDMA, page, 1'b1, da, 1, $urandom_range(0, 1));
                default: issue(1'b0, 16'h0000, 8'h00, 1'b1, da, 0, $urandom_range(0, 1));
            endcase
            wait_idle();
            wa = 16'($urandom);
            if (wa == REG_OAMDMA) wa = 16'h4015;
            issue(1'b1, wa, 8'($urandom), 1'b0, 16'h0000, 0, -1);
            repeat (4) @(posedge clk);
            check("no_halt_on_other_write", {31'd0, cpu_disable}, 32'd0);
        end

        // Reset at index $10: outputs clear asynchronously, nothing resumes.
        base = n_writes;
        issue(1'b1, REG_OAMDMA, 8'h09, 1'b0, 16'h0000, 0, -1);
        wait_writes(base + 8'h10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_disable", {31'd0, cpu_disable}, 32'd0);
        check("arst_en", {31'd0, dma_en}, 32'd0);
        check("arst_addr", {16'd0, dma_addr}, 32'd0);
        check("arst_write", {31'd0, dma_wr}, 32'd0);
        check("arst_data", {24'd0, dma_data}, 32'd0);
        check("arst_ack", {31'd0, dmc_ack}, 32'd0);
        check("arst_dmc_data", {24'd0, dmc_data}, 32'd0);
        oam_q.delete();
        dmc_q.delete();
        len_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = n_writes;
        repeat (600) @(posedge clk);
        #1;
        check("post_reset_writes", n_writes - base, 0);
        check("post_reset_idle", {31'd0, cpu_disable}, 32'd0);

        check("leftover_oam", oam_q.size(), 0);
        check("leftover_dmc", dmc_q.size(), 0);
        check("leftover_len", len_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule : tb_oam_dma_controller
